// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control/handshake bundle between sequencer and datapath/memory
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [CNT_W-1:0] instret;
  logic             halted;
  logic             bus_error;
  logic             illegal_instr;
  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, addr_src, ir_write, pc_write, reg_write,
    output instret, halted, bus_error, illegal_instr
  );
  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, addr_src, ir_write, pc_write, reg_write,
    input  instret, halted, bus_error, illegal_instr
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog and retire counter
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_sequencer_if.master bus
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                         OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam int WW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [2:0]       state, next;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] instret_q;
  logic             store_q, bus_err_q, illegal_q;
  logic             is_load, is_store, is_branch, known, timeout;
  always_comb begin
    is_load   = bus.opcode == OP_LOAD;
    is_store  = bus.opcode == OP_STORE;
    is_branch = bus.opcode == OP_BRANCH;
    known     = is_load || is_store || is_branch ||
                bus.opcode inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    // mem_we comes from a flag latched in EXEC so it stays a pure state decode
    bus.mem_req       = state == FETCH || state == MEM;
    bus.mem_we        = state == MEM && store_q;
    bus.addr_src      = state == MEM;
    bus.ir_write      = state == FETCH && bus.mem_ready;
    bus.pc_write      = (state == EXEC && is_branch) || (state == MEM && store_q && bus.mem_ready) || state == WB;
    bus.reg_write     = state == WB;
    bus.halted        = state == TRAP;
    bus.bus_error     = bus_err_q;
    bus.illegal_instr = illegal_q;
    bus.instret       = instret_q;
    timeout = TIMEOUT_CYCLES != 0 && bus.mem_req && !bus.mem_ready && wait_cnt == WW'(TIMEOUT_CYCLES);
    case (state)
      FETCH:   next = timeout ? TRAP : bus.mem_ready ? DECODE : FETCH;
      DECODE:  next = known ? EXEC : TRAP;
      EXEC:    next = (is_load || is_store) ? MEM : is_branch ? FETCH : WB;
      MEM:     next = timeout ? TRAP : !bus.mem_ready ? MEM : store_q ? FETCH : WB;
      WB:      next = FETCH;
      default: next = TRAP;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      instret_q <= '0;
      store_q   <= 1'b0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state    <= next;
      wait_cnt <= (next != state || bus.mem_ready) ? '0 : bus.mem_req ? wait_cnt + WW'(1) : wait_cnt;
      if (bus.pc_write) instret_q <= instret_q + CNT_W'(1);
      if (state == EXEC) store_q <= is_store;
      if (timeout) bus_err_q <= 1'b1;
      if (state == DECODE && !known) illegal_q <= 1'b1;
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction stream checked against a per-instruction cycle-trace model
module tb_multicycle_sequencer;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011,
                         RTYPE = 7'b0110011, ITYPE = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = '0;
  logic [6:0] ops [9] = '{LOAD, STORE, BRANCH, RTYPE, ITYPE, LUI, AUIPC, JAL, JALR};
  multicycle_sequencer_if #(.CNT_W(32)) bus ();
  multicycle_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  // {mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, halted}
  function automatic logic [6:0] vec();
    return {bus.mem_req, bus.mem_we, bus.addr_src, bus.ir_write, bus.pc_write, bus.reg_write, bus.halted};
  endfunction
  // Expected per-cycle outputs of one instruction given its fetch and memory wait counts
  function automatic void model(input logic [6:0] op, input int fw, input int mw,
                                output logic [111:0] tr, output int n);
    tr = '0;
    n  = 0;
    for (int i = 0; i <= fw; i++) begin tr = {tr[104:0], (i == fw) ? 7'b1001000 : 7'b1000000}; n++; end
    tr = {tr[104:0], 7'b0000000}; n++;
    tr = {tr[104:0], (op == BRANCH) ? 7'b0000100 : 7'b0000000}; n++;
    if (op == LOAD || op == STORE)
      for (int i = 0; i <= mw; i++) begin
        tr = {tr[104:0], 1'b1, op == STORE, 1'b1, 1'b0, op == STORE && i == mw, 2'b00};
        n++;
      end
    if (op != STORE && op != BRANCH) begin tr = {tr[104:0], 7'b0000110}; n++; end
  endfunction
  // Acts as the memory: answers each access after the requested number of wait cycles
  task automatic run_instr(input logic [6:0] op, input logic bt, input int fw, input int mw,
                           output logic [111:0] tr, output int n);
    int   acc = 0;
    int   waited = 0;
    logic done = 1'b0;
    tr = '0;
    n  = 0;
    bus.opcode = op;
    bus.branch_taken = bt;
    while (!done && n < 16) begin
      @(negedge clk);
      bus.mem_ready = bus.mem_req && waited == (acc == 0 ? fw : mw);
      #1;
      tr = {tr[104:0], vec()};
      n++;
      if (bus.mem_req) begin
        if (bus.mem_ready) begin acc++; waited = 0; end
        else waited++;
      end
      done = bus.pc_write || bus.halted;
    end
  endtask
  task automatic apply_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_instret = '0;
  endtask
  task automatic test_reset();
    bus.opcode = '0;
    bus.branch_taken = 1'b0;
    apply_reset();
    checks++; if (vec() !== 7'b1000000) begin errors++; $display("FAIL reset_outputs got %b exp %b", vec(), 7'b1000000); end
    checks++; if (bus.instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %h exp 0", bus.instret); end
    checks++; if ({bus.bus_error, bus.illegal_instr} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus.bus_error, bus.illegal_instr}); end
  endtask
  task automatic test_addi();
    logic [111:0] got, exp;
    int gn, en;
    run_instr(ITYPE, 1'b0, 0, 0, got, gn);
    model(ITYPE, 0, 0, exp, en);
    checks++; if (gn !== en || got !== exp) begin errors++; $display("FAIL addi_trace got %0d/%h exp %0d/%h", gn, got, en, exp); end
    @(posedge clk); #1;
    exp_instret++;
    checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL addi_instret got %h exp %h", bus.instret, exp_instret); end
  endtask
  task automatic test_load_wait();
    logic [111:0] got, exp;
    int gn, en;
    run_instr(LOAD, 1'b0, 0, 3, got, gn);
    model(LOAD, 0, 3, exp, en);
    checks++; if (gn !== 8) begin errors++; $display("FAIL lw_latency got %0d exp 8", gn); end
    checks++; if (got !== exp) begin errors++; $display("FAIL lw_trace got %h exp %h", got, exp); end
    @(posedge clk); #1;
    exp_instret++;
    checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL lw_instret got %h exp %h", bus.instret, exp_instret); end
  endtask
  task automatic test_store_branch();
    logic [111:0] got, exp;
    int gn, en;
    logic [6:0] seq_op [3] = '{STORE, BRANCH, BRANCH};
    logic       seq_bt [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      run_instr(seq_op[k], seq_bt[k], 0, 0, got, gn);
      model(seq_op[k], 0, 0, exp, en);
      checks++; if (gn !== en || got !== exp) begin errors++; $display("FAIL st_br_trace[%0d] got %0d/%h exp %0d/%h", k, gn, got, en, exp); end
      @(posedge clk); #1;
      exp_instret++;
    end
    checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL st_br_instret got %h exp %h", bus.instret, exp_instret); end
  endtask
  task automatic test_random();
    logic [111:0] got, exp;
    int gn, en, fw, mw;
    logic [6:0] op;
    for (int k = 0; k < 24; k++) begin
      op = ops[$urandom_range(0, 8)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr(op, 1'($urandom_range(0, 1)), fw, mw, got, gn);
      model(op, fw, mw, exp, en);
      checks++; if (gn !== en || got !== exp) begin errors++; $display("FAIL rand_trace[%0d] op %b got %0d/%h exp %0d/%h", k, op, gn, got, en, exp); end
      @(posedge clk); #1;
      exp_instret++;
      checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL rand_instret[%0d] got %h exp %h", k, bus.instret, exp_instret); end
    end
  endtask
  task automatic test_wrap();
    logic [111:0] got, exp;
    int gn, en;
    apply_reset();
    force u_dut.instret_q = 32'hFFFF_FFFF;
    #1 release u_dut.instret_q;
    #1;
    exp_instret = 32'hFFFF_FFFF;
    checks++; if (bus.instret !== exp_instret) begin errors++; $display("FAIL wrap_preload got %h exp %h", bus.instret, exp_instret); end
    run_instr(ITYPE, 1'b0, 0, 0, got, gn);
    model(ITYPE, 0, 0, exp, en);
    checks++; if (gn !== en || got !== exp) begin errors++; $display("FAIL wrap_trace got %0d/%h exp %0d/%h", gn, got, en, exp); end
    @(posedge clk); #1;
    exp_instret++;
    checks++; if (bus.instret !== exp_instret || exp_instret !== 32'd0) begin errors++; $display("FAIL wrap_instret got %h exp 0", bus.instret); end
    checks++; if ({bus.bus_error, bus.illegal_instr, bus.halted} !== 3'b000) begin errors++; $display("FAIL wrap_side_effects got %b exp 000", {bus.bus_error, bus.illegal_instr, bus.halted}); end
  endtask
  task automatic test_illegal();
    logic [111:0] got;
    int gn;
    logic ok = 1'b1;
    apply_reset();
    run_instr(7'b1111111, 1'b0, 0, 0, got, gn);
    checks++; if (gn !== 3 || got[20:0] !== {7'b1001000, 7'b0000000, 7'b0000001}) begin errors++; $display("FAIL illegal_trace got %0d/%h exp 3/%h", gn, got[20:0], {7'b1001000, 7'b0000000, 7'b0000001}); end
    checks++; if ({bus.illegal_instr, bus.bus_error} !== 2'b10) begin errors++; $display("FAIL illegal_flags got %b exp 10", {bus.illegal_instr, bus.bus_error}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (vec() !== 7'b0000001 || bus.illegal_instr !== 1'b1 || bus.instret !== exp_instret) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL illegal_frozen got %b exp %b", vec(), 7'b0000001); end
  endtask
  task automatic test_reset_mid_mem();
    apply_reset();
    bus.opcode = STORE;
    @(negedge clk) bus.mem_ready = 1'b1;
    @(negedge clk) bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (vec() !== 7'b1110000) begin errors++; $display("FAIL midmem_store got %b exp %b", vec(), 7'b1110000); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (vec() !== 7'b1000000 || bus.instret !== exp_instret) begin errors++; $display("FAIL midmem_after_rst got %b/%h exp %b/%h", vec(), bus.instret, 7'b1000000, exp_instret); end
  endtask
  task automatic test_timeout();
    int   reqs = 0;
    logic ok = 1'b1;
    apply_reset();
    for (int i = 0; i < 20 && !bus.halted; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      if (bus.mem_req) reqs++;
    end
    checks++; if (reqs !== 5) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 5", reqs); end
    checks++; if (vec() !== 7'b0000001 || bus.bus_error !== 1'b1 || bus.illegal_instr !== 1'b0) begin errors++; $display("FAIL timeout_trap got %b/%b%b exp 0000001/10", vec(), bus.bus_error, bus.illegal_instr); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode = ops[$urandom_range(0, 8)];
      #1;
      if (vec() !== 7'b0000001 || bus.bus_error !== 1'b1 || bus.instret !== exp_instret) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL timeout_frozen got %b exp %b", vec(), 7'b0000001); end
    apply_reset();
    checks++; if (vec() !== 7'b1000000 || bus.bus_error !== 1'b0) begin errors++; $display("FAIL timeout_rst got %b/%b exp 1000000/0", vec(), bus.bus_error); end
  endtask
  // Mem-wait cycles and a near-limit wait: 3 waits with TIMEOUT_CYCLES=4 must not trap
  task automatic test_back_to_back();
    logic [111:0] got, exp;
    int gn, en;
    run_instr(STORE, 1'b0, 3, 3, got, gn);
    model(STORE, 3, 3, exp, en);
    checks++; if (gn !== en || got !== exp) begin errors++; $display("FAIL b2b_store got %0d/%h exp %0d/%h", gn, got, en, exp); end
    @(posedge clk); #1;
    exp_instret++;
    run_instr(JAL, 1'b0, 0, 0, got, gn);
    model(JAL, 0, 0, exp, en);
    checks++; if (gn !== en || got !== exp) begin errors++; $display("FAIL b2b_jal got %0d/%h exp %0d/%h", gn, got, en, exp); end
    @(posedge clk); #1;
    exp_instret++;
    checks++; if (bus.instret !== exp_instret || bus.bus_error !== 1'b0) begin errors++; $display("FAIL b2b_instret got %h/%b exp %h/0", bus.instret, bus.bus_error, exp_instret); end
  endtask
  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_load_wait();
    test_store_branch();
    test_back_to_back();
    test_random();
    test_wrap();
    test_illegal();
    test_reset_mid_mem();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
